// File: rtl/pattern_input_ctrl.sv
// -----------------------------------------------------------------------------
// pattern_input_ctrl
//
// Round controller for the player-input phase of the memory game. When a round
// starts it latches the target sequence and the required number of entries.
// It then watches the four pushbuttons for presses and checks each press
// against the next expected entry. While the player plays it drives the shared
// box drawer: the pressed box is highlighted on a correct press and cleared
// again once every key is released. A round ends with a one-cycle oDone when
// every entry has matched. It ends with a one-cycle oLost on a wrong key or
// when several keys go down in the same cycle.
//
// Ports
//   iClock      system clock, all state on the rising edge
//   iResetn     asynchronous active-low reset
//   iStart      begin a round (only looked at while idle)
//   iLevel      entries required this round, saturated to MAX_LEN
//   iPattern    entry k = bits [2k+1:2k], key index 0..3
//   iKey        active-low pushbuttons, already synchronised to iClock
//   oBoxReq     draw request to the box drawer
//   oBoxX/Y     top-left corner of the box to draw
//   oBoxColour  colour of the box to draw
//   iBoxDone    one-cycle completion pulse from the drawer
//   oBusy       high whenever a round is in progress (any state but idle)
//   oMatched    number of correct entries so far this round
//   oDone       one-cycle pulse, round passed
//   oLost       one-cycle pulse, round failed
// -----------------------------------------------------------------------------
module pattern_input_ctrl #(
    parameter int unsigned MAX_LEN    = 16,
    parameter logic [2:0]  HI_COLOUR  = 3'd5,
    parameter logic [2:0]  CLR_COLOUR = 3'd7
) (
    input  logic                   iClock,
    input  logic                   iResetn,
    input  logic                   iStart,
    input  logic [4:0]             iLevel,
    input  logic [2*MAX_LEN-1:0]   iPattern,
    input  logic [3:0]             iKey,
    output logic                   oBoxReq,
    output logic [7:0]             oBoxX,
    output logic [6:0]             oBoxY,
    output logic [2:0]             oBoxColour,
    input  logic                   iBoxDone,
    output logic                   oBusy,
    output logic [4:0]             oMatched,
    output logic                   oDone,
    output logic                   oLost
);

    // Wide enough to hold the value MAX_LEN itself (round length).
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_KEY = 3'd1,
        S_DRAW_HI  = 3'd2,
        S_WAIT_REL = 3'd3,
        S_DRAW_CLR = 3'd4,
        S_LOST     = 3'd5,
        S_DONE     = 3'd6
    } state_e;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Number of bits set in a 4-bit vector (0..4).
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Key index of a one-hot press vector; only meaningful when exactly one bit is set.
    function automatic logic [1:0] onehot_to_key(input logic [3:0] v);
        case (v)
            4'b0001: onehot_to_key = 2'd0;
            4'b0010: onehot_to_key = 2'd1;
            4'b0100: onehot_to_key = 2'd2;
            4'b1000: onehot_to_key = 2'd3;
            default: onehot_to_key = 2'd0;
        endcase
    endfunction

    // Screen position {x[7:0], y[6:0]} of the 24x24 box belonging to each key.
    function automatic logic [14:0] box_pos(input logic [1:0] key);
        case (key)
            2'd0:    box_pos = {8'd38, 7'd69};
            2'd1:    box_pos = {8'd68, 7'd84};
            2'd2:    box_pos = {8'd68, 7'd54};
            2'd3:    box_pos = {8'd98, 7'd69};
            default: box_pos = {8'd0,  7'd0};
        endcase
    endfunction

    // Entry 'idx' of the latched pattern. Written as a compare loop so that
    // every bit select uses a constant index.
    function automatic logic [1:0] pattern_entry(input logic [2*MAX_LEN-1:0] pat,
                                                 input logic [LEN_W-1:0]     idx);
        pattern_entry = 2'd0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (idx == LEN_W'(i)) begin
                pattern_entry = pat[2*i +: 2];
            end else begin
                pattern_entry = pattern_entry;
            end
        end
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e               state_q,   state_d;
    logic [3:0]           key_prev_q;
    logic [2*MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]     len_q,     len_d;
    logic [LEN_W-1:0]     idx_q,     idx_d;
    logic                 req_q,     req_d;
    logic [7:0]           x_q,       x_d;
    logic [6:0]           y_q,       y_d;
    logic [2:0]           col_q,     col_d;
    logic                 busy_q,    busy_d;
    logic [4:0]           matched_q, matched_d;
    logic                 done_q,    done_d;
    logic                 lost_q,    lost_d;

    // -------------------------------------------------------------------------
    // Derived signals
    // -------------------------------------------------------------------------
    logic [3:0]       press_s;
    logic [2:0]       press_cnt_s;
    logic [1:0]       press_key_s;
    logic [1:0]       expected_key_s;
    logic [LEN_W-1:0] idx_inc_s;
    logic [LEN_W-1:0] level_sat_s;

    // Press detection, next expected entry and saturated round length.
    always_comb begin
        // A press is a high-to-low edge of an active-low key.
        press_s        = key_prev_q & ~iKey;
        press_cnt_s    = popcount4(press_s);
        press_key_s    = onehot_to_key(press_s);
        expected_key_s = pattern_entry(pattern_q, idx_q);
        idx_inc_s      = idx_q + LEN_W'(1);
        if ({27'd0, iLevel} > 32'(MAX_LEN)) begin
            level_sat_s = LEN_W'(MAX_LEN);
        end else begin
            level_sat_s = LEN_W'(iLevel);
        end
    end

    // Next-state and next-output logic for the round FSM.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        idx_d     = idx_q;
        req_d     = req_q;
        x_d       = x_q;
        y_d       = y_q;
        col_d     = col_q;
        matched_d = matched_q;
        done_d    = 1'b0;
        lost_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    pattern_d = iPattern;
                    len_d     = level_sat_s;
                    idx_d     = '0;
                    matched_d = 5'd0;
                    if (level_sat_s == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT_KEY;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_WAIT_KEY: begin
                if (press_cnt_s == 3'd0) begin
                    state_d = S_WAIT_KEY;
                end else if (press_cnt_s != 3'd1) begin
                    state_d = S_LOST;
                    lost_d  = 1'b1;
                end else if (press_key_s == expected_key_s) begin
                    // Request is raised together with the state change so the
                    // drawer sees it one cycle after the press.
                    state_d    = S_DRAW_HI;
                    req_d      = 1'b1;
                    {x_d, y_d} = box_pos(press_key_s);
                    col_d      = HI_COLOUR;
                end else begin
                    state_d = S_LOST;
                    lost_d  = 1'b1;
                end
            end

            S_DRAW_HI: begin
                // Further presses are deliberately ignored while drawing.
                if (iBoxDone) begin
                    req_d   = 1'b0;
                    state_d = S_WAIT_REL;
                end else begin
                    state_d = S_DRAW_HI;
                end
            end

            S_WAIT_REL: begin
                if (iKey == 4'hF) begin
                    // Same box as the highlight: x/y are still held.
                    state_d = S_DRAW_CLR;
                    req_d   = 1'b1;
                    col_d   = CLR_COLOUR;
                end else begin
                    state_d = S_WAIT_REL;
                end
            end

            S_DRAW_CLR: begin
                if (iBoxDone) begin
                    req_d     = 1'b0;
                    idx_d     = idx_inc_s;
                    matched_d = matched_q + 5'd1;
                    if (idx_inc_s == len_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT_KEY;
                    end
                end else begin
                    state_d = S_DRAW_CLR;
                end
            end

            S_LOST: begin
                state_d = S_IDLE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                // Unreachable encoding: recover to idle with the drawer released.
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; the key history updates every cycle in every state.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state_q    <= S_IDLE;
            key_prev_q <= 4'hF;
            pattern_q  <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            req_q      <= 1'b0;
            x_q        <= 8'd0;
            y_q        <= 7'd0;
            col_q      <= 3'd0;
            busy_q     <= 1'b0;
            matched_q  <= 5'd0;
            done_q     <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_prev_q <= iKey;
            pattern_q  <= pattern_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            req_q      <= req_d;
            x_q        <= x_d;
            y_q        <= y_d;
            col_q      <= col_d;
            busy_q     <= busy_d;
            matched_q  <= matched_d;
            done_q     <= done_d;
            lost_q     <= lost_d;
        end
    end

    assign oBoxReq    = req_q;
    assign oBoxX      = x_q;
    assign oBoxY      = y_q;
    assign oBoxColour = col_q;
    assign oBusy      = busy_q;
    assign oMatched   = matched_q;
    assign oDone      = done_q;
    assign oLost      = lost_q;

endmodule
